// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serialiser between NUM_REQ byte requesters,
// plus the free-running 16x baud tick. Define UART_TX_SCHED_PRIO_EN for requester-0 strict priority.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned BAUD    = 115_200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*8-1:0]       i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  output logic                       o_baud_pulse,
  input  logic                       i_uart_tx_done,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * 16);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = $clog2(NUM_REQ);
  localparam logic [CW-1:0] BaudMax = CW'(DIV - 1);

  generate
    if (DIV < 1) begin : g_div_chk
      $error("uart_tx_sched: CLK_HZ too low for BAUD, DIV < 1");
    end
    if (NUM_REQ < 2) begin : g_req_chk
      $error("uart_tx_sched: NUM_REQ must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_baud_cnt;
  logic            r_baud_pulse;
  logic [NUM_REQ-1:0] r_req_ready, w_req_ready_nxt;
  logic            r_tx_start, w_tx_start_nxt;
  logic [7:0]      r_tx_data, w_tx_data_nxt;
  logic            r_busy, w_busy_nxt;
  logic [IW-1:0]   r_grant_id, w_grant_id_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic            w_found;
  logic [IW-1:0]   w_win;
  logic [IW-1:0]   w_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt   <= '0;
      r_baud_pulse <= 1'b0;
    end else begin
      r_baud_pulse <= (r_baud_cnt == BaudMax);
      r_baud_cnt   <= (r_baud_cnt == BaudMax) ? '0 : r_baud_cnt + 1'b1;
    end
  end

  // First valid requester found scanning upward from the one after the last grant.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
`ifdef UART_TX_SCHED_PRIO_EN
    if (i_req_valid[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end
`endif
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = '0;
    w_tx_start_nxt  = 1'b0;
    w_tx_data_nxt   = r_tx_data;
    w_busy_nxt      = r_busy;
    w_grant_id_nxt  = r_grant_id;
    w_rr_ptr_nxt    = r_rr_ptr;
    case (r_state)
      StIdle: begin
        if (w_found) begin
          w_req_ready_nxt[w_win] = 1'b1;
          w_tx_data_nxt          = i_req_data[8*w_win +: 8];
          w_grant_id_nxt         = w_win;
          w_busy_nxt             = 1'b1;
          w_state_nxt            = StIssue;
`ifdef UART_TX_SCHED_PRIO_EN
          // Requester-0 grants leave the rotation of 1..N-1 untouched.
          if (!i_req_valid[0]) begin
            w_rr_ptr_nxt = w_win;
          end
`else
          w_rr_ptr_nxt = w_win;
`endif
        end
      end
      StIssue: begin
        w_tx_start_nxt = 1'b1;
        w_state_nxt    = StWait;
      end
      StWait: begin
        if (i_uart_tx_done) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_req_ready <= '0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_busy      <= 1'b0;
      r_grant_id  <= '0;
      r_rr_ptr    <= IW'(NUM_REQ - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_tx_start  <= w_tx_start_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_busy      <= w_busy_nxt;
      r_grant_id  <= w_grant_id_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_baud_pulse = r_baud_pulse;
  assign o_busy       = r_busy;
  assign o_grant_id   = r_grant_id;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural uart_tx model on the baud tick, arbitration reference model.
module tb_uart_tx_sched;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  r_valid = '0;
  logic [31:0] r_data = '0;
  logic        inj_done = 1'b0;
  logic [3:0]  w_ready;
  logic        w_start;
  logic [7:0]  w_data;
  logic        w_baud;
  logic        w_busy;
  logic [1:0]  w_grant;
  logic        w_done;

  int checks = 0;
  int errors = 0;
  int tpb = 1;
  int p_model = N - 1;

  // uart_tx model: 10-bit frame, tpb baud ticks per bit, 1-cycle done pulse
  logic       u_active = 1'b0;
  logic       u_line = 1'b1;
  logic       u_done = 1'b0;
  logic [9:0] u_frame = '0;
  int         u_bit = 0;
  int         u_tick = 0;
  int         u_overlap = 0;

  always #5 clk = ~clk;

  assign w_done = u_done | inj_done;

  uart_tx_sched #(.NUM_REQ(4), .CLK_HZ(1_600_000), .BAUD(10_000)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_valid   (r_valid),
    .i_req_data    (r_data),
    .o_req_ready   (w_ready),
    .o_tx_start    (w_start),
    .o_tx_data     (w_data),
    .o_baud_pulse  (w_baud),
    .i_uart_tx_done(w_done),
    .o_busy        (w_busy),
    .o_grant_id    (w_grant)
  );

  always @(posedge clk) begin
    u_done <= 1'b0;
    if (rst) begin
      u_active <= 1'b0;
      u_line   <= 1'b1;
    end else if (!u_active) begin
      if (w_start) begin
        u_active <= 1'b1;
        u_frame  <= {1'b1, w_data, 1'b0};
        u_bit    <= 0;
        u_tick   <= 0;
        u_line   <= 1'b0;
      end
    end else begin
      if (w_start) u_overlap <= u_overlap + 1;
      if (w_baud) begin
        if (u_tick == tpb - 1) begin
          u_tick <= 0;
          if (u_bit == 9) begin
            u_active <= 1'b0;
            u_done   <= 1'b1;
            u_line   <= 1'b1;
          end else begin
            u_bit  <= u_bit + 1;
            u_line <= u_frame[u_bit+1];
          end
        end else begin
          u_tick <= u_tick + 1;
        end
      end
    end
  end

  // Winner = valid requester with the smallest forward distance from the pointer.
  function automatic int exp_win(input logic [3:0] v, input int p);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
`ifdef UART_TX_SCHED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - p - 1 + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    rst      = 1'b1;
    r_valid  = '0;
    inj_done = 1'b0;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    p_model = N - 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (w_ready !== 4'b0) begin errors++; $display("FAIL rst_ready got %0h want 0", w_ready); end
    checks++; if (w_start !== 1'b0) begin errors++; $display("FAIL rst_start got %0h want 0", w_start); end
    checks++; if (w_data !== 8'h00) begin errors++; $display("FAIL rst_data got %0h want 0", w_data); end
    checks++; if (w_baud !== 1'b0) begin errors++; $display("FAIL rst_baud got %0h want 0", w_baud); end
    checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h want 0", w_busy); end
    checks++; if (w_grant !== 2'd0) begin errors++; $display("FAIL rst_grant got %0h want 0", w_grant); end
  endtask

  task automatic test_single();
    logic [9:0] got;
    logic [9:0] want;
    int nbits;
    int last;
    bit to;
    want  = 10'b11_0100_1010;
    got   = '0;
    nbits = 0;
    last  = -1;
    to    = 1'b1;
    tpb   = 16;
    do_reset();
    r_data[7:0] = 8'hA5;
    r_valid     = 4'b0001;
    @(negedge clk);
    checks++; if (w_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %0h want 1", w_ready); end
    checks++; if (w_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %0h want 0", w_start); end
    checks++; if (w_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0h want 1", w_busy); end
    r_valid = '0;
    @(negedge clk);
    checks++; if (w_start !== 1'b1 || w_data !== 8'hA5) begin
      errors++; $display("FAIL single_start got start=%0h data=%0h want 1/a5", w_start, w_data);
    end
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (u_active && u_bit != last) begin
        if (nbits < 10) got[nbits] = u_line;
        nbits++;
        last = u_bit;
      end
      if (w_done) begin
        to = 1'b0;
        break;
      end
      checks++; if (w_busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold got %0h want 1", w_busy); end
    end
    checks++; if (to) begin errors++; $display("FAIL single_done_timeout got timeout want done"); end
    checks++; if (nbits !== 10 || got !== want) begin
      errors++; $display("FAIL single_line got n=%0d bits=%b want n=10 bits=%b", nbits, got, want);
    end
    @(negedge clk);
    checks++; if (w_busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop got %0h want 0", w_busy); end
    tpb = 1;
  endtask

  task automatic test_baud();
    int cnt;
    int first;
    int prev;
    int badgap;
    cnt    = 0;
    first  = -1;
    prev   = -1;
    badgap = 0;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (w_baud) begin
        if (first < 0) first = k;
        if (prev >= 0 && k - prev != 10) badgap++;
        prev = k;
        cnt++;
      end
    end
    checks++; if (cnt !== 10) begin errors++; $display("FAIL baud_count got %0d want 10", cnt); end
    checks++; if (first !== 9) begin errors++; $display("FAIL baud_first got %0d want 9", first); end
    checks++; if (badgap !== 0) begin errors++; $display("FAIL baud_gap got %0d bad want 0", badgap); end
  endtask

  task automatic test_done_idle();
    bit to;
    to = 1'b1;
    do_reset();
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (w_busy !== 1'b0 || w_ready !== 4'b0 || w_start !== 1'b0) begin
        errors++; $display("FAIL idle_done got busy=%0h ready=%0h start=%0h want 0/0/0", w_busy, w_ready, w_start);
      end
    end
    r_valid = 4'hF;
    @(negedge clk);
    checks++; if (w_ready !== 4'b0001 || w_grant !== 2'd0) begin
      errors++; $display("FAIL idle_done_grant got ready=%0h grant=%0h want 1/0", w_ready, w_grant);
    end
    r_valid = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (w_done) begin
        to = 1'b0;
        break;
      end
    end
    checks++; if (to) begin errors++; $display("FAIL idle_done_timeout got timeout want done"); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit to;
    to = 1'b1;
    do_reset();
    r_data[23:16] = 8'h3C;
    r_valid       = 4'b0100;
    @(negedge clk);
    checks++; if (w_ready !== 4'b0100) begin errors++; $display("FAIL mid_first got %0h want 4", w_ready); end
    r_valid     = 4'b0001;
    r_data[7:0] = 8'h5A;
    repeat (6) @(negedge clk);
    r_valid[2] = 1'b1;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (w_ready !== 4'b0 || w_start !== 1'b0 || w_data !== 8'h00) begin
      errors++; $display("FAIL mid_rst_out got ready=%0h start=%0h data=%0h want 0/0/0", w_ready, w_start, w_data);
    end
    checks++; if (w_baud !== 1'b0 || w_busy !== 1'b0 || w_grant !== 2'd0) begin
      errors++; $display("FAIL mid_rst_st got baud=%0h busy=%0h grant=%0h want 0/0/0", w_baud, w_busy, w_grant);
    end
    @(negedge clk);
    checks++; if (w_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart got %0h want 1", w_ready); end
    r_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (w_start !== 1'b1 || w_data !== 8'h5A) begin
      errors++; $display("FAIL mid_start got start=%0h data=%0h want 1/5a", w_start, w_data);
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (w_done) begin
        to = 1'b0;
        break;
      end
    end
    checks++; if (to) begin errors++; $display("FAIL mid_done_timeout got timeout want done"); end
    repeat (2) @(negedge clk);
    checks++; if (w_ready !== 4'b0100) begin errors++; $display("FAIL mid_second got %0h want 4", w_ready); end
    r_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_traffic(input int mode);
    int w;
    int nfr;
    logic [7:0] ed;
    bit to;
    do_reset();
    tpb = 1;
    nfr = (mode == 0) ? 5 : (mode == 1) ? 24 : 4;
    if (mode == 0) begin
      r_valid = 4'hF;
      for (int i = 0; i < N; i++) r_data[8*i +: 8] = 8'(16 + i);
    end
    if (mode == 2) begin
      r_valid       = 4'b0011;
      r_data[7:0]   = 8'h60;
      r_data[15:8]  = 8'h61;
    end
    for (int f = 0; f < nfr; f++) begin
      if (mode == 2 && f == 3) r_valid[0] = 1'b0;
      if (mode == 1) begin
        for (int g = 0; g < 6 && r_valid == 4'b0; g++) begin
          for (int i = 0; i < N; i++) begin
            if (!r_valid[i] && $urandom_range(0, 2) == 0) begin
              r_valid[i]       = 1'b1;
              r_data[8*i +: 8] = 8'($urandom);
            end
          end
          if (r_valid == 4'b0) begin
            @(negedge clk);
            checks++; if (w_ready !== 4'b0) begin errors++; $display("FAIL tr_idle_ready got %0h want 0", w_ready); end
          end
        end
        if (r_valid == 4'b0) begin
          w                = $urandom_range(0, 3);
          r_valid[w]       = 1'b1;
          r_data[8*w +: 8] = 8'($urandom);
        end
      end
      w  = exp_win(r_valid, p_model);
      ed = r_data[8*w +: 8];
      @(negedge clk);
      checks++; if (w_ready !== 4'(1 << w) || w_grant !== 2'(w) || w_busy !== 1'b1) begin
        errors++;
        $display("FAIL tr_grant m%0d f%0d got ready=%0h grant=%0d busy=%0h want ready=%0h grant=%0d busy=1",
                 mode, f, w_ready, w_grant, w_busy, 4'(1 << w), w);
      end
`ifdef UART_TX_SCHED_PRIO_EN
      if (w != 0) p_model = w;
`else
      p_model = w;
`endif
      if (mode == 1) r_valid[w] = 1'b0;
      @(negedge clk);
      checks++; if (w_start !== 1'b1 || w_data !== ed || w_ready !== 4'b0) begin
        errors++; $display("FAIL tr_start m%0d f%0d got start=%0h data=%0h ready=%0h want 1/%0h/0",
                           mode, f, w_start, w_data, w_ready, ed);
      end
      to = 1'b1;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (mode == 1) begin
          for (int i = 0; i < N; i++) begin
            if (!r_valid[i] && $urandom_range(0, 7) == 0) begin
              r_valid[i]       = 1'b1;
              r_data[8*i +: 8] = 8'($urandom);
            end
          end
        end
        checks++; if (w_start !== 1'b0 || w_data !== ed || w_busy !== 1'b1) begin
          errors++; $display("FAIL tr_wait m%0d f%0d got start=%0h data=%0h busy=%0h want 0/%0h/1",
                             mode, f, w_start, w_data, w_busy, ed);
        end
        if (w_done) begin
          to = 1'b0;
          break;
        end
      end
      checks++; if (to) begin errors++; $display("FAIL tr_done_timeout m%0d f%0d got timeout want done", mode, f); end
      @(negedge clk);
      checks++; if (w_busy !== 1'b0 || w_ready !== 4'b0) begin
        errors++; $display("FAIL tr_release m%0d f%0d got busy=%0h ready=%0h want 0/0", mode, f, w_busy, w_ready);
      end
    end
    r_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_baud();
    test_done_idle();
    test_mid_reset();
    test_traffic(0);
    test_traffic(1);
`ifdef UART_TX_SCHED_PRIO_EN
    test_traffic(2);
`endif
    checks++; if (u_overlap !== 0) begin errors++; $display("FAIL start_overlap got %0d want 0", u_overlap); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
